uart_tx_scheduler: RTL and testbench
====================================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Param NUM_REQ, default 4: number of byte requesters sharing one UART transmitter (2..8).
REQ-002 Param SIZE_DATA, default 8: byte width, equal to the transmitter data width.
REQ-003 Param TIMEOUT_CYC, default 65535: maximum clocks to wait for the done pulse before aborting a frame.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 i_clk  in  1  system clock.
REQ-006 i_rst  in  1  async active-high reset.
REQ-007 i_enable  in  1  high allows new grants; low blocks new grants, but an in-flight frame completes.
REQ-008 i_req_valid  in  NUM_REQ  per-requester byte-available flag.
REQ-009 i_req_data  in  NUM_REQ*SIZE_DATA  per-requester byte; requester k uses slice [k*SIZE_DATA +: SIZE_DATA].
REQ-010 o_req_ready  out  NUM_REQ  one-hot accept; a transfer occurs when valid&ready.
REQ-011 o_tx_en  out  1  start strobe to the transmitter.
REQ-012 o_fifo_empty  out  1  low only together with o_tx_en; high otherwise.
REQ-013 o_tx_data  out  SIZE_DATA  held byte to the transmitter.
REQ-014 i_tx_done  in  1  one-cycle frame-complete pulse from the transmitter.
REQ-015 o_grant_id  out  clog2(NUM_REQ)  index of the current or last granted requester.
REQ-016 o_busy  out  1  high from accept until return to IDLE.
REQ-017 o_done  out  NUM_REQ  one-hot, one-cycle completion pulse to the owning requester.
REQ-018 o_timeout  out  1  one-cycle pulse on watchdog abort.

Function
REQ-019 FSM states: IDLE, LAUNCH, WAIT_DONE.
REQ-020 IDLE with i_enable=1 and any valid: combinationally assert o_req_ready for exactly one winner; on the clock edge, latch the winner's byte into o_tx_data and its index into o_grant_id, then go to LAUNCH.
REQ-021 Round-robin winner selection: first valid requester scanning upward from (last_grant+1) mod NUM_REQ, with wrap-around.
REQ-022 last_grant updates only on an accepted transfer.
REQ-023 o_req_ready is 0 in every state other than IDLE, and 0 when i_enable=0.
REQ-024 LAUNCH: o_tx_en=1 and o_fifo_empty=0 for exactly one cycle, then go to WAIT_DONE unconditionally.
REQ-025 WAIT_DONE: o_tx_data and o_grant_id are held stable. The watchdog counter increments each cycle from 0.
REQ-026 WAIT_DONE exit on completion: i_tx_done=1 -> pulse o_done[o_grant_id] in the next cycle, go to IDLE.
REQ-027 WAIT_DONE exit on timeout: counter==TIMEOUT_CYC-1 without done -> pulse o_timeout, no o_done pulse, go to IDLE.
REQ-028 Simultaneous done and timeout: done wins; no o_timeout pulse.
REQ-029 i_tx_done outside WAIT_DONE is ignored.
REQ-030 Minimum gap: a new grant can occur in the first IDLE cycle after WAIT_DONE (back-to-back arbitration).
REQ-031 i_enable falling during LAUNCH or WAIT_DONE has no effect until the return to IDLE.
REQ-032 Watchdog counter width is clog2(TIMEOUT_CYC+1); it clears on entry to WAIT_DONE.

Reset
REQ-033 On reset: state=IDLE, o_tx_en=0, o_fifo_empty=1, o_tx_data=0, o_grant_id=0, o_busy=0, o_done=0, o_timeout=0, counter=0.
REQ-034 On reset: last_grant=NUM_REQ-1, so requester 0 has first priority.
REQ-035 Reset mid-frame: abort immediately and issue no o_done pulse; transmitter recovery is its own reset's concern.

Structure
REQ-036 Shared package uart_pkg holds the scheduler state enum and the SIZE_DATA default.
REQ-037 A single sub-module rr_arbiter (combinational: valid vector + pointer -> one-hot grant + index) holds the selection logic. The FSM, holding register and watchdog live in the top module.

Verification
REQ-038 After reset, valid=4'b0101 with bytes 0x11/0x33 -> grant req0 first (ready=0001, o_tx_data=0x11); after done, grant req2 (0x33).
REQ-039 All four requesters valid continuously, done 20 cycles after each launch -> grant order 0,1,2,3,0; o_tx_en one cycle per frame.
REQ-040 Withhold i_tx_done with TIMEOUT_CYC=16 -> o_timeout pulses 16 cycles after WAIT_DONE entry, o_done stays 0, and the next grant follows.
REQ-041 Drop i_enable during WAIT_DONE with req1 valid -> the frame completes with an o_done pulse, no further ready while enable=0, and req1 is granted on the cycle enable returns.
REQ-042 Assert i_rst during WAIT_DONE -> all outputs return to reset values on the next sample; after release, req0 has first priority.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
package uart_pkg;

  // Scheduler FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2
  } sched_state_t;

  // Default byte width; matches the transmitter data path.
  localparam int SIZE_DATA_DEF = 8;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin selector: first valid requester above the last grant.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_valid,
  input  logic [$clog2(NUM_REQ)-1:0] i_last,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_idx,
  output logic                       o_any
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] cand;

  // Scan upward from last+1 with wrap; the last candidate checked is i_last itself.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    cand    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((int'(i_last) + i) % NUM_REQ);
      if (!o_any && i_valid[cand]) begin
        o_any         = 1'b1;
        o_idx         = cand;
        o_grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Schedules bytes from several requesters onto one UART transmitter.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | arbitrating; ready offered to one winner when enabled
// ST_LAUNCH    | one-cycle start strobe to the transmitter
// ST_WAIT_DONE | waiting for the done pulse, watchdog counting
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int SIZE_DATA   = SIZE_DATA_DEF,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_enable,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  input  logic [NUM_REQ*SIZE_DATA-1:0] i_req_data,
  output logic [NUM_REQ-1:0]           o_req_ready,
  output logic                         o_tx_en,
  output logic                         o_fifo_empty,
  output logic [SIZE_DATA-1:0]         o_tx_data,
  input  logic                         i_tx_done,
  output logic [$clog2(NUM_REQ)-1:0]   o_grant_id,
  output logic                         o_busy,
  output logic [NUM_REQ-1:0]           o_done,
  output logic                         o_timeout
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  sched_state_t state_q, state_d;

  logic [IW-1:0]        last_grant_q;
  logic [CW-1:0]        cnt_q;
  logic [NUM_REQ-1:0]   arb_grant;
  logic [IW-1:0]        arb_idx;
  logic                 arb_any;
  logic [SIZE_DATA-1:0] win_data;
  logic                 accept;
  logic                 done_hit;
  logic                 timeout_hit;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .i_valid(i_req_valid),
    .i_last (last_grant_q),
    .o_grant(arb_grant),
    .o_idx  (arb_idx),
    .o_any  (arb_any)
  );

  // Pick the winning requester's byte with constant slices.
  always_comb begin
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (arb_idx == IW'(k)) win_data = i_req_data[k*SIZE_DATA +: SIZE_DATA];
    end
  end

  // Next-state logic; done takes priority over the watchdog terminal count.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    done_hit    = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_enable && arb_any) begin
          accept  = 1'b1;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (i_tx_done) begin
          done_hit = 1'b1;
          state_d  = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_req_ready  = (state_q == ST_IDLE && i_enable) ? arb_grant : '0;
  assign o_tx_en      = (state_q == ST_LAUNCH);
  assign o_fifo_empty = (state_q != ST_LAUNCH);
  assign o_busy       = (state_q != ST_IDLE);

  // State, holding register, pointer, watchdog and completion pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      o_tx_data    <= '0;
      o_grant_id   <= '0;
      last_grant_q <= IW'(NUM_REQ - 1);
      cnt_q        <= '0;
      o_done       <= '0;
      o_timeout    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        o_tx_data    <= win_data;
        o_grant_id   <= arb_idx;
        last_grant_q <= arb_idx;
      end
      if (state_q == ST_LAUNCH)         cnt_q <= '0;
      else if (state_q == ST_WAIT_DONE) cnt_q <= cnt_q + CW'(1);
      o_done <= '0;
      if (done_hit) o_done[o_grant_id] <= 1'b1;
      o_timeout <= timeout_hit;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler; a second instance uses a short watchdog.
module tb_uart_tx_scheduler;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_enable = 1'b0;
  logic [3:0]  i_req_valid = '0;
  logic [31:0] i_req_data = 32'h44_33_22_11;
  logic        i_tx_done = 1'b0;

  logic [3:0] o_req_ready, o_done;
  logic       o_tx_en, o_fifo_empty, o_busy, o_timeout;
  logic [7:0] o_tx_data;
  logic [1:0] o_grant_id;

  logic [3:0] ready_t, done_t;
  logic       tx_en_t, fifo_empty_t, busy_t, timeout_t;
  logic [7:0] tx_data_t;
  logic [1:0] grant_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  uart_tx_scheduler #(.NUM_REQ(4), .SIZE_DATA(8), .TIMEOUT_CYC(65535)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable),
    .i_req_valid(i_req_valid), .i_req_data(i_req_data),
    .o_req_ready(o_req_ready), .o_tx_en(o_tx_en), .o_fifo_empty(o_fifo_empty),
    .o_tx_data(o_tx_data), .i_tx_done(i_tx_done), .o_grant_id(o_grant_id),
    .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout)
  );

  uart_tx_scheduler #(.NUM_REQ(4), .SIZE_DATA(8), .TIMEOUT_CYC(16)) dut_t (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable),
    .i_req_valid(i_req_valid), .i_req_data(i_req_data),
    .o_req_ready(ready_t), .o_tx_en(tx_en_t), .o_fifo_empty(fifo_empty_t),
    .o_tx_data(tx_data_t), .i_tx_done(i_tx_done), .o_grant_id(grant_t),
    .o_busy(busy_t), .o_done(done_t), .o_timeout(timeout_t)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    repeat (2) tick();
    i_rst = 1'b0;
    #1;
  endtask

  task automatic pulse_done();
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
  endtask

  task automatic test_reset();
    i_req_valid = '0;
    i_enable    = 1'b1;
    i_rst       = 1'b1;
    tick();
    n_checks++;
    if ({o_tx_en, o_fifo_empty, o_busy, o_timeout} !== 4'b0100) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0100", {o_tx_en, o_fifo_empty, o_busy, o_timeout});
    end
    n_checks++;
    if ({o_tx_data, o_grant_id, o_done} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_regs: data=%h id=%0d done=%b expected 0", o_tx_data, o_grant_id, o_done);
    end
    n_checks++;
    if (o_req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 0000", o_req_ready);
    end
    do_reset();
  endtask

  task automatic test_basic();
    i_req_valid = 4'b0101;
    i_enable    = 1'b1;
    do_reset();
    n_checks++;
    if (o_req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL basic_ready0: got %b expected 0001", o_req_ready);
    end
    tick();
    n_checks++;
    if ({o_tx_en, o_fifo_empty, o_busy, o_req_ready} !== 7'b1010000) begin
      n_fail++;
      $display("FAIL basic_launch: en/empty/busy/ready got %b expected 1010000",
               {o_tx_en, o_fifo_empty, o_busy, o_req_ready});
    end
    n_checks++;
    if (o_tx_data !== 8'h11 || o_grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL basic_data0: got %h id %0d expected 11 id 0", o_tx_data, o_grant_id);
    end
    i_req_valid = 4'b0100;
    tick();
    n_checks++;
    if ({o_tx_en, o_fifo_empty} !== 2'b01) begin
      n_fail++;
      $display("FAIL basic_strobe_len: got %b expected 01", {o_tx_en, o_fifo_empty});
    end
    repeat (3) tick();
    pulse_done();
    n_checks++;
    if (o_done !== 4'b0001 || o_busy !== 1'b0 || o_req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL basic_done0: done=%b busy=%b ready=%b expected 0001 0 0100", o_done, o_busy, o_req_ready);
    end
    tick();
    n_checks++;
    if (o_tx_data !== 8'h33 || o_grant_id !== 2'd2 || o_tx_en !== 1'b1 || o_done !== 4'b0000) begin
      n_fail++;
      $display("FAIL basic_data2: data=%h id=%0d en=%b done=%b expected 33 2 1 0000",
               o_tx_data, o_grant_id, o_tx_en, o_done);
    end
    i_req_valid = '0;
    repeat (3) tick();
    pulse_done();
    n_checks++;
    if (o_done !== 4'b0100) begin
      n_fail++;
      $display("FAIL basic_done2: got %b expected 0100", o_done);
    end
    pulse_done();
    n_checks++;
    if (o_done !== 4'b0000 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_done_ignored: done=%b busy=%b expected 0000 0", o_done, o_busy);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_oh;
    int         exp_id;
    int         tx_cnt;
    i_req_valid = 4'b1111;
    i_enable    = 1'b1;
    do_reset();
    for (int f = 0; f < 5; f++) begin
      exp_id = f % 4;
      exp_oh = 4'b0001 << exp_id;
      n_checks++;
      if (o_req_ready !== exp_oh) begin
        n_fail++;
        $display("FAIL rr_ready[%0d]: got %b expected %b", f, o_req_ready, exp_oh);
      end
      tick();
      tx_cnt = int'(o_tx_en);
      n_checks++;
      if (o_grant_id !== 2'(exp_id) || o_tx_data !== exp_bytes[exp_id]) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: id=%0d data=%h expected %0d %h",
                 f, o_grant_id, o_tx_data, exp_id, exp_bytes[exp_id]);
      end
      for (int i = 1; i <= 20; i++) begin
        tick();
        tx_cnt += int'(o_tx_en);
      end
      pulse_done();
      n_checks++;
      if (o_done !== exp_oh || tx_cnt != 1) begin
        n_fail++;
        $display("FAIL rr_done[%0d]: done=%b tx_en_cycles=%0d expected %b 1", f, o_done, tx_cnt, exp_oh);
      end
    end
    i_req_valid = '0;
  endtask

  task automatic test_timeout();
    i_req_valid = 4'b0010;
    i_enable    = 1'b1;
    do_reset();
    n_checks++;
    if (ready_t !== 4'b0010) begin
      n_fail++;
      $display("FAIL to_ready: got %b expected 0010", ready_t);
    end
    tick();
    tick();
    for (int i = 1; i <= 15; i++) begin
      tick();
      n_checks++;
      if (timeout_t !== 1'b0 || done_t !== 4'b0000) begin
        n_fail++;
        $display("FAIL to_early[%0d]: timeout=%b done=%b expected 0 0000", i, timeout_t, done_t);
      end
    end
    tick();
    n_checks++;
    if (timeout_t !== 1'b1 || done_t !== 4'b0000 || busy_t !== 1'b0 || ready_t !== 4'b0010) begin
      n_fail++;
      $display("FAIL to_pulse: timeout=%b done=%b busy=%b ready=%b expected 1 0000 0 0010",
               timeout_t, done_t, busy_t, ready_t);
    end
    tick();
    n_checks++;
    if (timeout_t !== 1'b0 || tx_en_t !== 1'b1 || grant_t !== 2'd1) begin
      n_fail++;
      $display("FAIL to_next: timeout=%b en=%b id=%0d expected 0 1 1", timeout_t, tx_en_t, grant_t);
    end
    i_req_valid = '0;
    tick();
    repeat (15) tick();
    pulse_done();
    n_checks++;
    if (done_t !== 4'b0010 || timeout_t !== 1'b0) begin
      n_fail++;
      $display("FAIL done_beats_timeout: done=%b timeout=%b expected 0010 0", done_t, timeout_t);
    end
  endtask

  task automatic test_enable();
    i_req_valid = 4'b0001;
    i_enable    = 1'b1;
    do_reset();
    tick();
    i_req_valid = 4'b0010;
    tick();
    i_enable = 1'b0;
    repeat (3) tick();
    pulse_done();
    n_checks++;
    if (o_done !== 4'b0001 || o_req_ready !== 4'b0000 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL en_complete: done=%b ready=%b busy=%b expected 0001 0000 0", o_done, o_req_ready, o_busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (o_req_ready !== 4'b0000 || o_tx_en !== 1'b0 || o_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL en_blocked[%0d]: ready=%b en=%b busy=%b expected 0000 0 0", i, o_req_ready, o_tx_en, o_busy);
      end
    end
    i_enable = 1'b1;
    #1;
    n_checks++;
    if (o_req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL en_return_ready: got %b expected 0010", o_req_ready);
    end
    tick();
    n_checks++;
    if (o_tx_en !== 1'b1 || o_grant_id !== 2'd1 || o_tx_data !== 8'h22) begin
      n_fail++;
      $display("FAIL en_return_grant: en=%b id=%0d data=%h expected 1 1 22", o_tx_en, o_grant_id, o_tx_data);
    end
    i_req_valid = '0;
    tick();
    pulse_done();
  endtask

  task automatic test_reset_mid();
    i_req_valid = 4'b0100;
    i_enable    = 1'b1;
    do_reset();
    tick();
    i_req_valid = '0;
    tick();
    repeat (3) tick();
    i_rst = 1'b1;
    #1;
    n_checks++;
    if ({o_tx_en, o_fifo_empty, o_busy, o_timeout} !== 4'b0100 ||
        o_tx_data !== 8'h00 || o_grant_id !== 2'd0 || o_done !== 4'b0000) begin
      n_fail++;
      $display("FAIL midreset_outputs: flags=%b data=%h id=%0d done=%b expected 0100 00 0 0000",
               {o_tx_en, o_fifo_empty, o_busy, o_timeout}, o_tx_data, o_grant_id, o_done);
    end
    tick();
    i_rst = 1'b0;
    tick();
    n_checks++;
    if (o_done !== 4'b0000 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_nodone: done=%b busy=%b expected 0000 0", o_done, o_busy);
    end
    i_req_valid = 4'b1111;
    #1;
    n_checks++;
    if (o_req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL midreset_priority: got %b expected 0001", o_req_ready);
    end
    i_req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_timeout();
    test_enable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
